// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// RV32I instruction decode stage sitting between fetch and execute.
//
// Each accepted instruction is split into its opcode, register and funct
// fields and its sign-extended immediate, and is checked against the RV32I
// subset handled here. The decoded result is stored, together with the fetch
// PC, in a 2-entry skid buffer. Fetch and execute can therefore stall
// independently, and in_ready never depends combinationally on out_ready.
//
// Ports
//   clk        in   1               rising-edge clock
//   rst        in   1               synchronous active-high reset; empties the
//                                   buffer and zeroes all data outputs
//   flush      in   1               empties the buffer and drops any accept in
//                                   the same cycle (branch redirect)
//   in_valid   in   1               fetch presents inst/in_pc
//   in_ready   out  1               buffer has a free entry
//   inst       in   INST_WIDTH      raw instruction
//   in_pc      in   PC_WIDTH        PC of inst
//   out_valid  out  1               head entry is valid
//   out_ready  in   1               execute consumes the head entry
//   op         out  7               inst[6:0]
//   rd         out  REG_ADDR_WIDTH  inst[11:7]
//   rs1        out  REG_ADDR_WIDTH  inst[19:15]
//   rs2        out  REG_ADDR_WIDTH  inst[24:20]
//   funct3     out  3               inst[14:12]
//   funct7     out  7               inst[31:25]
//   imm        out  XLEN            sign-extended immediate (0 if illegal)
//   out_pc     out  PC_WIDTH        PC of the head instruction
//   illegal    out  1               head instruction is not legal RV32I
// -----------------------------------------------------------------------------
module decode_stage #(
    parameter int XLEN           = 32,
    parameter int INST_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int PC_WIDTH       = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INST_WIDTH-1:0]     inst,
    input  logic [PC_WIDTH-1:0]       in_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [6:0]                op,
    output logic [REG_ADDR_WIDTH-1:0] rd,
    output logic [REG_ADDR_WIDTH-1:0] rs1,
    output logic [REG_ADDR_WIDTH-1:0] rs2,
    output logic [2:0]                funct3,
    output logic [6:0]                funct7,
    output logic [XLEN-1:0]           imm,
    output logic [PC_WIDTH-1:0]       out_pc,
    output logic                      illegal
);

    localparam logic [6:0] OP_LUI         = 7'b0110111;
    localparam logic [6:0] OP_AUIPC       = 7'b0010111;
    localparam logic [6:0] OP_JAL         = 7'b1101111;
    localparam logic [6:0] OP_JALR        = 7'b1100111;
    localparam logic [6:0] OP_LOAD        = 7'b0000011;
    localparam logic [6:0] OP_STORE       = 7'b0100011;
    localparam logic [6:0] OP_BRANCH      = 7'b1100011;
    localparam logic [6:0] OP_INTEGER_IMM = 7'b0010011;
    localparam logic [6:0] OP_INTEGER     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // One buffer entry: everything execute needs, decoded once at accept time.
    typedef struct packed {
        logic [6:0]                op;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [2:0]                funct3;
        logic [6:0]                funct7;
        logic [XLEN-1:0]           imm;
        logic [PC_WIDTH-1:0]       pc;
        logic                      ill;
    } entry_t;

    // Widen a 32-bit signed immediate to XLEN, replicating the sign bit.
    function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
        logic signed [XLEN-1:0] w;
        w = v;
        return w;
    endfunction

    // Legality check for the supported RV32I subset.
    function automatic logic is_illegal(input logic [6:0] opc,
                                        input logic [2:0] f3,
                                        input logic [6:0] f7);
        logic bad;
        bad = 1'b0;
        case (opc)
            OP_LUI, OP_AUIPC, OP_JAL: bad = 1'b0;
            OP_JALR:   bad = (f3 != 3'b000);
            OP_LOAD:   bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            OP_STORE:  bad = (f3 >= 3'b011);
            OP_BRANCH: bad = (f3 == 3'b010) || (f3 == 3'b011);
            OP_INTEGER_IMM: begin
                // Only the shifts carry a funct7; SLLI has no arithmetic form.
                if (f3 == 3'b001)
                    bad = (f7 != F7_BASE);
                else if (f3 == 3'b101)
                    bad = (f7 != F7_BASE) && (f7 != F7_ALT);
                else
                    bad = 1'b0;
            end
            OP_INTEGER: begin
                // The alternate funct7 exists only for SUB and SRA.
                if (f7 == F7_BASE)
                    bad = 1'b0;
                else if (f7 == F7_ALT)
                    bad = (f3 != 3'b000) && (f3 != 3'b101);
                else
                    bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Immediate selection by format; INTEGER has no immediate.
    function automatic logic [XLEN-1:0] sel_imm(input logic [31:0] i);
        logic [31:0] v;
        case (i[6:0])
            OP_LUI, OP_AUIPC:
                v = {i[31:12], 12'b0};
            OP_JAL:
                v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            OP_JALR, OP_LOAD, OP_INTEGER_IMM:
                v = {{20{i[31]}}, i[31:20]};
            OP_BRANCH:
                v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            OP_STORE:
                v = {{20{i[31]}}, i[31:25], i[11:7]};
            default:
                v = 32'b0;
        endcase
        return sext32(v);
    endfunction

    function automatic entry_t decode(input logic [INST_WIDTH-1:0] i,
                                      input logic [PC_WIDTH-1:0]   pc);
        entry_t e;
        logic [31:0] w;
        w        = i[31:0];
        e.op     = w[6:0];
        e.rd     = REG_ADDR_WIDTH'(w[11:7]);
        e.rs1    = REG_ADDR_WIDTH'(w[19:15]);
        e.rs2    = REG_ADDR_WIDTH'(w[24:20]);
        e.funct3 = w[14:12];
        e.funct7 = w[31:25];
        e.pc     = pc;
        e.ill    = is_illegal(w[6:0], w[14:12], w[31:25]);
        // Illegal instructions travel downstream with a zero immediate.
        e.imm    = e.ill ? '0 : sel_imm(w);
        return e;
    endfunction

    entry_t     dec_p0;
    entry_t     head_p1;   // oldest entry; drives the outputs directly
    entry_t     tail_p1;   // second entry, only meaningful when count is 2
    logic [1:0] count_p1;
    logic       accept;
    logic       consume;

    assign dec_p0    = decode(inst, in_pc);
    assign in_ready  = (count_p1 != 2'd2);
    assign out_valid = (count_p1 != 2'd0);
    assign accept    = in_valid && in_ready && !flush;
    assign consume   = out_valid && out_ready;

    // ---- stage boundary: decoded entry -> skid buffer (registered outputs) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            count_p1 <= 2'd0;
            head_p1  <= '0;
            tail_p1  <= '0;
        end else if (flush) begin
            count_p1 <= 2'd0;
        end else begin
            case ({accept, consume})
                2'b10: begin
                    if (count_p1 == 2'd0)
                        head_p1 <= dec_p0;
                    else
                        tail_p1 <= dec_p0;
                    count_p1 <= count_p1 + 2'd1;
                end
                2'b01: begin
                    // Promote the second entry; harmless when it is empty
                    // because out_valid drops with the count.
                    head_p1  <= tail_p1;
                    count_p1 <= count_p1 - 2'd1;
                end
                2'b11: begin
                    // Both can fire only with exactly one entry held, so the
                    // new instruction replaces the departing head.
                    head_p1 <= dec_p0;
                end
                default: begin
                end
            endcase
        end
    end

    assign op      = head_p1.op;
    assign rd      = head_p1.rd;
    assign rs1     = head_p1.rs1;
    assign rs2     = head_p1.rs2;
    assign funct3  = head_p1.funct3;
    assign funct7  = head_p1.funct7;
    assign imm     = head_p1.imm;
    assign out_pc  = head_p1.pc;
    assign illegal = head_p1.ill;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] inst, in_pc, imm, out_pc;
    logic [6:0]  op, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        illegal;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    exp_t q[$];

    decode_stage #(.XLEN(32), .INST_WIDTH(32), .REG_ADDR_WIDTH(5), .PC_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
        .imm(imm), .out_pc(out_pc), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decoder: legality from per-opcode allowed-funct tables,
    // immediates rebuilt with integer arithmetic from the bit positions.
    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
        exp_t e;
        int   f3, f7, v;
        bit   legal;
        f3 = int'(i[14:12]);
        f7 = int'(i[31:25]);
        v  = 0;
        legal = 1'b1;
        case (int'(i[6:0]))
            'h37, 'h17: v = int'(i & 32'hFFFFF000);
            'h6f: begin
                v = int'(i[31]) * (1 << 20) + int'(i[19:12]) * (1 << 12)
                  + int'(i[20]) * (1 << 11) + int'(i[30:21]) * 2;
                if (v >= (1 << 20)) v -= (1 << 21);
            end
            'h67, 'h03, 'h13: begin
                v = int'(i[31:20]);
                if (v >= 2048) v -= 4096;
                if (int'(i[6:0]) == 'h67) legal = (f3 == 0);
                if (int'(i[6:0]) == 'h03) legal = (f3 inside {0, 1, 2, 4, 5});
                if (int'(i[6:0]) == 'h13 && f3 == 1) legal = (f7 == 0);
                if (int'(i[6:0]) == 'h13 && f3 == 5) legal = (f7 == 0 || f7 == 32);
            end
            'h23: begin
                v = int'(i[31:25]) * 32 + int'(i[11:7]);
                if (v >= 2048) v -= 4096;
                legal = (f3 < 3);
            end
            'h63: begin
                v = int'(i[31]) * 4096 + int'(i[7]) * 2048
                  + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
                if (v >= 4096) v -= 8192;
                legal = !(f3 == 2 || f3 == 3);
            end
            'h33: legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
            default: legal = 1'b0;
        endcase
        e.op  = i[6:0];
        e.rd  = i[11:7];
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
        e.f3  = i[14:12];
        e.f7  = i[31:25];
        e.pc  = pc;
        e.ill = !legal;
        e.imm = legal ? 32'(v) : 32'h0;
        return e;
    endfunction

    // Called at a negedge: check current outputs against the model, drive the
    // next inputs, advance the model across the coming posedge.
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [31:0] i, input logic [31:0] p, input logic ordy);
        exp_t obs;
        bit   acc, con;
        chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
        chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
        if (q.size() > 0) begin
            obs = {op, rd, rs1, rs2, funct3, funct7, imm, out_pc, illegal};
            chk("head", 128'(obs), 128'(q[0]));
        end
        rst = r; flush = f; in_valid = iv; inst = i; in_pc = p; out_ready = ordy;
        if (r || f) begin
            q.delete();
        end else begin
            acc = iv && (q.size() < 2);
            con = (q.size() > 0) && ordy;
            if (con) void'(q.pop_front());
            if (acc) q.push_back(ref_decode(i, p));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [6:0] opcs [9] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h23, 7'h63, 7'h13, 7'h33};

    initial begin
        logic [31:0] r32;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        inst = '0; in_pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_data", 128'({op, rd, rs1, rs2, funct3, funct7, imm, out_pc, illegal}), 128'(0));

        // Directed decode vectors
        step(0, 0, 1, 32'h00500093, 32'h100, 1);
        chk("addi_fields", 128'({out_valid, op, rd, rs1, imm, illegal}),
            128'({1'b1, 7'h13, 5'd1, 5'd0, 32'h5, 1'b0}));
        step(0, 0, 1, 32'hFE000EE3, 32'h104, 1);
        chk("beq_fields", 128'({imm, funct3, illegal}), 128'({32'hFFFFFFFC, 3'd0, 1'b0}));
        step(0, 0, 1, 32'h123452B7, 32'h108, 1);
        chk("lui_fields", 128'({imm, rd}), 128'({32'h12345000, 5'd5}));
        step(0, 0, 1, 32'h00000000, 32'h10C, 1);
        chk("zero_illegal", 128'({illegal, imm}), 128'({1'b1, 32'h0}));
        step(0, 0, 0, 32'h0, 32'h0, 1);

        // Backpressure: three back-to-back, only two fit
        step(0, 0, 1, 32'h00100113, 32'h200, 0);
        step(0, 0, 1, 32'h00200193, 32'h204, 0);
        chk("full_in_ready", 128'(in_ready), 128'(0));
        step(0, 0, 1, 32'h00300213, 32'h208, 0);
        chk("still_full", 128'(in_ready), 128'(0));
        chk("first_head", 128'(out_pc), 128'(32'h200));
        step(0, 0, 1, 32'h00300213, 32'h208, 1);
        chk("second_head", 128'(out_pc), 128'(32'h204));
        step(0, 0, 1, 32'h00300213, 32'h208, 1);
        chk("third_head", 128'(out_pc), 128'(32'h208));
        step(0, 0, 0, 32'h0, 32'h0, 1);
        chk("drained", 128'(out_valid), 128'(0));

        // Flush with a full buffer and a concurrent offer
        step(0, 0, 1, 32'h00400293, 32'h300, 0);
        step(0, 0, 1, 32'h00500313, 32'h304, 0);
        step(0, 1, 1, 32'h00600393, 32'h308, 0);
        chk("flush_out_valid", 128'(out_valid), 128'(0));
        step(0, 0, 0, 32'h0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 32'h0, 1);
        chk("flush_dropped", 128'(out_valid), 128'(0));

        // Reset mid-stream with a full buffer
        step(0, 0, 1, 32'h00700413, 32'h400, 0);
        step(0, 0, 1, 32'h00800493, 32'h404, 0);
        step(1, 0, 1, 32'h00900513, 32'h408, 0);
        chk("mrst_out_valid", 128'(out_valid), 128'(0));
        chk("mrst_in_ready", 128'(in_ready), 128'(1));
        chk("mrst_data", 128'({op, rd, rs1, rs2, funct3, funct7, imm, out_pc, illegal}), 128'(0));

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            r32 = $urandom;
            if ($urandom_range(0, 7) != 0) r32[6:0] = opcs[$urandom_range(0, 8)];
            case ($urandom_range(0, 3))
                0: r32[31:25] = 7'h00;
                1: r32[31:25] = 7'h20;
                default: ;
            endcase
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 3) != 0), r32, $urandom,
                 ($urandom_range(0, 2) != 0));
        end
        for (int n = 0; n < 4; n++) step(0, 0, 0, 32'h0, 32'h0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
